// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit (mdu_iter).
// Opcode macros come from the shared execute-stage defines and are only supplied
// here if no earlier compilation unit has defined them.

`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif
`ifndef OP_ADD
`define OP_ADD 4'd0
`endif
`ifndef OP_MUL
`define OP_MUL 4'd9
`endif
`ifndef OP_DIV
`define OP_DIV 4'd10
`endif
`ifndef OP_MOD
`define OP_MOD 4'd11
`endif

package mdu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned ITER_N = 32;
   localparam int unsigned CNT_W  = $clog2(ITER_N);
   localparam int unsigned CMD_W  = `EXE_CMD_LEN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_e;

   typedef enum logic [1:0] {
      OPK_MUL = 2'd0,
      OPK_DIV = 2'd1,
      OPK_MOD = 2'd2
   } mdu_op_e;

   // True for the commands this unit accepts
   function automatic logic is_mdu_cmd(input logic [CMD_W-1:0] cmd);
      return (cmd == `OP_MUL) || (cmd == `OP_DIV) || (cmd == `OP_MOD);
   endfunction

   // Map an accepted command onto the internal operation kind
   function automatic mdu_op_e decode_cmd(input logic [CMD_W-1:0] cmd);
      if (cmd == `OP_MUL)      return OPK_MUL;
      else if (cmd == `OP_DIV) return OPK_DIV;
      else                     return OPK_MOD;
   endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// EX-stage <-> multiply/divide unit handshake and operand/result bus.

interface mdu_iter_if;
   import mdu_pkg::*;

   logic                 start;
   logic [CMD_W-1:0]     exe_cmd;
   logic [XLEN-1:0]      op_a;
   logic [XLEN-1:0]      op_b;
   logic [XLEN-1:0]      result;
   logic                 done;
   logic                 busy;
   logic                 div_by_zero;
   logic                 stall;

   // EX stage side
   modport master (
      output start, exe_cmd, op_a, op_b,
      input  result, done, busy, div_by_zero, stall
   );

   // Multiply/divide unit side
   modport slave (
      input  start, exe_cmd, op_a, op_b,
      output result, done, busy, div_by_zero, stall
   );
endinterface

// File: rtl/mdu_signfix.sv
// Sign handling for mdu_iter: operand magnitudes in, signed result out.

module mdu_signfix
   import mdu_pkg::*;
(
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_abs_a,
   output logic [XLEN-1:0] o_abs_b,
   input  logic [XLEN-1:0] i_mag,
   input  logic            i_neg,
   output logic [XLEN-1:0] o_fix
);

   // Two's-complement magnitudes; -2^31 maps to 32'h8000_0000 read as unsigned
   assign o_abs_a = i_a[XLEN-1] ? (-i_a) : i_a;
   assign o_abs_b = i_b[XLEN-1] ? (-i_b) : i_b;

   // Re-apply the result sign to the magnitude
   assign o_fix   = i_neg ? (-i_mag) : i_mag;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide/modulo unit for the EX stage.
// 32 shift-add / restoring-divide iterations on magnitudes plus one sign-fix cycle.
// Optional build macro MDU_FAST_MUL_EN: MUL completes in a single cycle.

module mdu_iter
   import mdu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   mdu_iter_if.slave  bus
);

   mdu_state_e        r_state, w_state_nxt;
   mdu_op_e           r_op, w_op_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_fin, w_fin_nxt;
   logic              r_sa, w_sa_nxt;
   logic              r_sb, w_sb_nxt;
   logic [XLEN-1:0]   r_opnd, w_opnd_nxt;
   logic [XLEN-1:0]   r_hi, w_hi_nxt;
   logic [XLEN-1:0]   r_lo, w_lo_nxt;
   logic [XLEN-1:0]   r_result, w_result_nxt;
   logic              r_dbz, w_dbz_nxt;
   logic              r_done, r_busy;

   logic              w_accept;
   mdu_op_e           w_op_in;
   logic [XLEN-1:0]   w_abs_a, w_abs_b;
   logic [XLEN-1:0]   w_fix_mag, w_fix;
   logic              w_fix_neg;
   logic [XLEN:0]     w_sum, w_shift, w_diff;
   logic              w_ge;
`ifdef MDU_FAST_MUL_EN
   logic [XLEN-1:0]   w_fast_prod;
`endif

   // Accept qualification and command decode
   assign w_accept = (r_state == IDLE) && bus.start && is_mdu_cmd(bus.exe_cmd);
   assign w_op_in  = decode_cmd(bus.exe_cmd);

   // Final magnitude/sign selection: MOD takes the remainder with the dividend sign
   assign w_fix_mag = (r_op == OPK_MOD) ? r_hi : r_lo;
   assign w_fix_neg = (r_op == OPK_MOD) ? r_sa : (r_sa ^ r_sb);

   mdu_signfix u_signfix (
      .i_a     (bus.op_a),
      .i_b     (bus.op_b),
      .o_abs_a (w_abs_a),
      .o_abs_b (w_abs_b),
      .i_mag   (w_fix_mag),
      .i_neg   (w_fix_neg),
      .o_fix   (w_fix)
   );

   // One shift-add step: {hi,lo} holds partial product with multiplier in lo
   assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);

   // One restoring-divide step: hi is partial remainder, lo shifts dividend out / quotient in
   assign w_shift = {r_hi, r_lo[XLEN-1]};
   assign w_diff  = w_shift - {1'b0, r_opnd};
   assign w_ge    = ~w_diff[XLEN];

`ifdef MDU_FAST_MUL_EN
   // Single-cycle product; low word is identical for signed and unsigned operands
   assign w_fast_prod = bus.op_a * bus.op_b;
`endif

   // Next-state and datapath update
   always_comb begin
      w_state_nxt  = r_state;
      w_op_nxt     = r_op;
      w_cnt_nxt    = r_cnt;
      w_fin_nxt    = r_fin;
      w_sa_nxt     = r_sa;
      w_sb_nxt     = r_sb;
      w_opnd_nxt   = r_opnd;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_result_nxt = r_result;
      w_dbz_nxt    = r_dbz;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_op_nxt  = w_op_in;
               w_sa_nxt  = bus.op_a[XLEN-1];
               w_sb_nxt  = bus.op_b[XLEN-1];
               w_cnt_nxt = '0;
               w_fin_nxt = 1'b0;
               w_hi_nxt  = '0;
               w_dbz_nxt = 1'b0;
               if (w_op_in == OPK_MUL) begin
                  w_opnd_nxt = w_abs_a;
                  w_lo_nxt   = w_abs_b;
               end else begin
                  w_opnd_nxt = w_abs_b;
                  w_lo_nxt   = w_abs_a;
               end

               if ((w_op_in != OPK_MUL) && (bus.op_b == '0)) begin
                  w_state_nxt  = DONE;
                  w_dbz_nxt    = 1'b1;
                  w_result_nxt = (w_op_in == OPK_DIV) ? '1 : bus.op_a;
               end
`ifdef MDU_FAST_MUL_EN
               else if (w_op_in == OPK_MUL) begin
                  w_state_nxt  = DONE;
                  w_result_nxt = w_fast_prod;
               end
`endif
               else begin
                  w_state_nxt = BUSY;
               end
            end
         end

         BUSY: begin
            if (r_fin) begin
               w_result_nxt = w_fix;
               w_state_nxt  = DONE;
            end else begin
               if (r_op == OPK_MUL) begin
                  w_hi_nxt = w_sum[XLEN:1];
                  w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
               end else begin
                  w_hi_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                  w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
               end
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(ITER_N - 1)) w_fin_nxt = 1'b1;
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
            w_dbz_nxt   = 1'b0;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_op     <= OPK_MUL;
         r_cnt    <= '0;
         r_fin    <= 1'b0;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_opnd   <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_op     <= w_op_nxt;
         r_cnt    <= w_cnt_nxt;
         r_fin    <= w_fin_nxt;
         r_sa     <= w_sa_nxt;
         r_sb     <= w_sb_nxt;
         r_opnd   <= w_opnd_nxt;
         r_hi     <= w_hi_nxt;
         r_lo     <= w_lo_nxt;
         r_result <= w_result_nxt;
         r_dbz    <= w_dbz_nxt;
         r_done   <= (w_state_nxt == DONE);
         r_busy   <= (w_state_nxt == BUSY);
      end
   end

   assign bus.result      = r_result;
   assign bus.done        = r_done;
   assign bus.busy        = r_busy;
   assign bus.div_by_zero = r_dbz;
   // Pipeline freeze: combinational so EX holds in the accept cycle itself
   assign bus.stall       = ~rst & (w_accept | (r_state == BUSY));

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: vector table + random ops through a result
// scoreboard, plus hand sequences for reset abort, non-MDU start and latency.

module tb_mdu_iter;
   import mdu_pkg::*;

   typedef struct {
      logic [CMD_W-1:0] cmd;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [31:0]      exp;
      logic             dbz;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic        dbz;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   mdu_iter_if bus();

   mdu_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic int exp_lat(input logic [CMD_W-1:0] cmd, input logic [31:0] b);
      if (cmd != `OP_MUL && b == 32'd0) return 1;
`ifdef MDU_FAST_MUL_EN
      if (cmd == `OP_MUL) return 1;
`endif
      return 34;
   endfunction

   // Scoreboard: compare every done pulse against the oldest expected result
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         exp_t e;
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected done: result %h with empty scoreboard", bus.result);
         end else begin
            e = sb_q.pop_front();
            if (bus.result !== e.res || bus.div_by_zero !== e.dbz) begin
               n_fail++;
               $display("FAIL result: got %h dbz %b, expected %h dbz %b",
                        bus.result, bus.div_by_zero, e.res, e.dbz);
            end
         end
      end
   end

   // Issue one op in the next IDLE cycle, inject bus noise while busy, wait for done
   task automatic run_op(input logic [CMD_W-1:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input logic dbz, input string tag);
      int   lat;
      logic stall_ok;
      exp_t e;
      @(negedge clk);
      check({tag, " done low before start"}, 32'(bus.done), 32'd0);
      bus.start   = 1'b1;
      bus.exe_cmd = cmd;
      bus.op_a    = a;
      bus.op_b    = b;
      e.res = exp;
      e.dbz = dbz;
      sb_q.push_back(e);
      #1;
      check({tag, " stall at accept"}, 32'(bus.stall), 32'd1);
      lat      = 0;
      stall_ok = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            lat = k;
            break;
         end
         if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_ok = 1'b0;
         bus.start   = 1'($urandom_range(0, 1));
         bus.exe_cmd = ($urandom_range(0, 1) != 0) ? `OP_MUL : `OP_DIV;
         bus.op_a    = $urandom;
         bus.op_b    = $urandom;
      end
      bus.start = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat(cmd, b)));
      check({tag, " stall/busy while busy"}, 32'(stall_ok), 32'd1);
      #1;
      check({tag, " stall in DONE"}, 32'(bus.stall), 32'd0);
   endtask

   vec_t vt[14];

   initial begin
      logic        saw;
      logic [CMD_W-1:0] rc;
      logic signed [31:0] sa, sb;
      logic [31:0] rexp;

      vt[0]  = '{`OP_MUL, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
      vt[1]  = '{`OP_DIV, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
      vt[2]  = '{`OP_MOD, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
      vt[3]  = '{`OP_DIV, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
      vt[4]  = '{`OP_MOD, 32'd5,          32'd0,         32'd5,         1'b1};
      vt[5]  = '{`OP_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
      vt[6]  = '{`OP_MOD, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0};
      vt[7]  = '{`OP_MUL, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
      vt[8]  = '{`OP_DIV, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
      vt[9]  = '{`OP_MOD, 32'd100,        32'hFFFF_FFF9, 32'd2,         1'b0};
      vt[10] = '{`OP_MUL, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 32'd15,        1'b0};
      vt[11] = '{`OP_MOD, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1'b1};
      vt[12] = '{`OP_DIV, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0};
      vt[13] = '{`OP_MUL, 32'h1234_5678,  32'h10,        32'h2345_6780, 1'b0};

      // Reset state, with a valid request presented during reset
      rst         = 1'b1;
      bus.start   = 1'b1;
      bus.exe_cmd = `OP_MUL;
      bus.op_a    = 32'd3;
      bus.op_b    = 32'd4;
      repeat (2) @(negedge clk);
      #1;
      check("reset result", bus.result, 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
      check("reset stall", 32'(bus.stall), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Vector table, issued back-to-back
      for (int i = 0; i < 14; i++)
         run_op(vt[i].cmd, vt[i].a, vt[i].b, vt[i].exp, vt[i].dbz, $sformatf("vec%0d", i));

      // Random operands against a signed-arithmetic model
      for (int i = 0; i < 6; i++) begin
         rc = (i % 3 == 0) ? `OP_MUL : ((i % 3 == 1) ? `OP_DIV : `OP_MOD);
         sa = $signed($urandom);
         sb = $signed($urandom >> $urandom_range(0, 28));
         if (sb == 0) sb = 1;
         if (sa == 32'sh8000_0000 && sb == -1) sb = 3;
         if (rc == `OP_MUL)      rexp = 32'(sa * sb);
         else if (rc == `OP_DIV) rexp = sa / sb;
         else                    rexp = sa % sb;
         run_op(rc, sa, sb, rexp, 1'b0, $sformatf("rnd%0d", i));
      end

      // Non-MDU command is not accepted and does not stall
      @(negedge clk);
      bus.start   = 1'b1;
      bus.exe_cmd = `OP_ADD;
      bus.op_a    = 32'd1;
      bus.op_b    = 32'd2;
      #1;
      check("add stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("add busy", 32'(bus.busy), 32'd0);
      check("add done", 32'(bus.done), 32'd0);

      // Reset during iteration 10 of a DIV discards the operation
      @(negedge clk);
      bus.start   = 1'b1;
      bus.exe_cmd = `OP_DIV;
      bus.op_a    = 32'd1000;
      bus.op_b    = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      check("pre-abort busy", 32'(bus.busy), 32'd1);
      rst         = 1'b1;
      bus.start   = 1'b1;
      bus.exe_cmd = `OP_MUL;
      #1;
      check("abort result", bus.result, 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
      check("abort stall", 32'(bus.stall), 32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw = 1'b1;
      end
      check("no done after abort", 32'(saw), 32'd0);
      run_op(`OP_MUL, 32'd3, 32'd3, 32'd9, 1'b0, "post-reset mul");

      repeat (3) @(negedge clk);
      check("scoreboard drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous active-high reset.
REQ-004 Port: start  input  1  EX stage presents an operation this cycle.
REQ-005 Port: exe_cmd  input  `EXE_CMD_LEN  execute command from ID/EX; only `OP_MUL, `OP_DIV, `OP_MOD are accepted.
REQ-006 Port: op_a  input  32  first operand (multiplicand / dividend), two's complement.
REQ-007 Port: op_b  input  32  second operand (multiplier / divisor), two's complement.
REQ-008 Port: result  output  32  product low word, quotient or remainder; valid only while done=1.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: busy  output  1  high in BUSY state.
REQ-011 Port: div_by_zero  output  1  qualifies done for DIV/MOD with op_b=0.
REQ-012 Port: stall  output  1  freeze request to the hazard/pipeline-register logic.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; encoding is free.
REQ-014 "Accept" SHALL mean state=IDLE, start=1 and exe_cmd in {`OP_MUL, `OP_DIV, `OP_MOD}; any other start SHALL be ignored with no state change.
REQ-015 On accept, operands, command and operand signs SHALL be latched; the next state is BUSY, except as REQ-020/REQ-026 state.
REQ-016 BUSY SHALL run exactly 32 iterations with a 5-bit counter from 0 to 31, then move to DONE.
REQ-017 MUL: shift-add on magnitudes; result = low 32 bits of the signed product.
REQ-018 DIV/MOD: restoring division on magnitudes; quotient truncates toward zero; remainder sign equals dividend sign.
REQ-019 Iterative latency: accept at edge N; done=1 in the cycle after edge N+33; DONE lasts one cycle, then IDLE.
REQ-020 Divide by zero: IDLE goes straight to DONE. DIV returns 32'hFFFF_FFFF, MOD returns op_a, and div_by_zero=1 with done.
REQ-021 -2^31 / -1 SHALL give quotient 32'h8000_0000 and remainder 0; no flag is raised.
REQ-022 stall SHALL be combinational: 1 when an accept condition holds in IDLE, or when state=BUSY; 0 in DONE, so EX captures result that cycle.
REQ-023 start and operand changes while BUSY or DONE SHALL be ignored.
REQ-024 Back-to-back: an accept is allowed in the IDLE cycle directly after DONE.

Reset
REQ-025 rst SHALL force IDLE asynchronously and zero the counter and all latched data. result, done, busy, div_by_zero and stall SHALL be 0 (stall=0 while rst=1), and any in-flight operation is discarded.

Configuration
REQ-026 Macro MDU_FAST_MUL_EN defined: MUL uses a single-cycle signed multiply, goes IDLE to DONE, and done asserts the cycle after accept. DIV/MOD are unchanged.
REQ-027 Macro MDU_FAST_MUL_EN undefined: MUL is iterative per REQ-016/REQ-019.

Structure
REQ-028 The state enum and the iteration-count constant (32) SHALL live in a shared package mdu_pkg. Opcode and `EXE_CMD_LEN values come from the existing shared defines.
REQ-029 Sign and magnitude handling SHALL be a sub-module mdu_signfix: absolute values in, result negation out. The datapath and FSM stay in mdu_iter.

Verification
REQ-030 MUL 7 x -6 (iterative build) -> done 34 cycles after the start cycle, result 32'hFFFF_FFD6; stall high from the start cycle through the last BUSY cycle.
REQ-031 DIV -7/2, then MOD -7/2 back-to-back -> results 32'hFFFF_FFFD and 32'hFFFF_FFFF; second accept in the IDLE cycle after the first DONE.
REQ-032 DIV 5/0 and MOD 5/0 -> done the cycle after accept; results 32'hFFFF_FFFF and 5; div_by_zero=1.
REQ-033 DIV 32'h8000_0000 / 32'hFFFF_FFFF -> result 32'h8000_0000, div_by_zero=0.
REQ-034 rst pulsed at iteration 10 of a DIV -> all outputs 0 immediately, no done pulse; a new MUL 3x3 afterwards returns 9.
REQ-035 MDU_FAST_MUL_EN build: MUL 3 x 4 -> done one cycle after accept, result 12; start with exe_cmd=`OP_ADD -> no accept, stall=0.
